// File: rtl/vend_ctrl_param_if.sv
// Coin/button and actuator signal bundle for vend_ctrl_param.
// master: the board-side driver of coins and cancel; slave: the controller.
interface vend_ctrl_param_if #(
  parameter int unsigned CREDIT_W = 4
);
  logic [1:0]          coin;
  logic                cancel;
  logic                dispense;
  logic                change_pulse;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                coin_reject;
`ifdef SALES_CNT_EN
  logic [7:0]          sales_count;
`endif

  modport master (
    output coin, cancel,
    input  dispense, change_pulse, credit, busy, coin_reject
`ifdef SALES_CNT_EN
    , input sales_count
`endif
  );

  modport slave (
    input  coin, cancel,
    output dispense, change_pulse, credit, busy, coin_reject
`ifdef SALES_CNT_EN
    , output sales_count
`endif
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// Parametrised coin vending controller: accumulates credit, vends at PRICE, returns change.
// Optional SALES_CNT_EN adds a saturating 8-bit sales counter.
module vend_ctrl_param #(
  parameter int unsigned PRICE      = 5,
  parameter int unsigned COIN_SMALL = 1,
  parameter int unsigned COIN_LARGE = 2,
  parameter int unsigned CREDIT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  vend_ctrl_param_if.slave   bus
);

  if (PRICE < 1 || (PRICE - 1 + COIN_LARGE) > ((1 << CREDIT_W) - 1)) begin : g_bad_params
    $error("vend_ctrl_param: credit register too narrow for PRICE/COIN_LARGE, or PRICE < 1");
  end

  localparam logic [CREDIT_W-1:0] PriceC = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] SmallC = CREDIT_W'(COIN_SMALL);
  localparam logic [CREDIT_W-1:0] LargeC = CREDIT_W'(COIN_LARGE);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StVend    = 3'd2,
    StChange  = 3'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;
  logic                coin_valid;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;

  // Large coin has priority; both bits set counts as one large coin.
  always_comb begin
    coin_valid = |bus.coin;
    coin_val   = '0;
    if (bus.coin[1]) begin
      coin_val = LargeC;
    end else if (bus.coin[0]) begin
      coin_val = SmallC;
    end
    sum = credit_q + coin_val;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    unique case (state_q)
      StIdle, StCollect: begin
        // Cancel only has effect with credit held; it then swallows any same-cycle coin.
        if (bus.cancel && state_q == StCollect) begin
          state_d  = StChange;
          reject_d = coin_valid;
        end else if (coin_valid) begin
          if (sum >= PriceC) begin
            state_d  = StVend;
            credit_d = sum - PriceC;
          end else begin
            state_d  = StCollect;
            credit_d = sum;
          end
        end
      end
      StVend: begin
        reject_d = coin_valid;
        state_d  = (credit_q != '0) ? StChange : StIdle;
      end
      StChange: begin
        reject_d = coin_valid;
        credit_d = credit_q - 1'b1;
        if (credit_q <= CREDIT_W'(1)) begin
          state_d  = StIdle;
          credit_d = '0;
        end
      end
      default: begin
        state_d  = StIdle;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  assign bus.dispense     = (state_q == StVend);
  assign bus.change_pulse = (state_q == StChange);
  assign bus.busy         = (state_q == StVend) || (state_q == StChange);
  assign bus.credit       = credit_q;
  assign bus.coin_reject  = reject_q;

`ifdef SALES_CNT_EN
  logic [7:0] sales_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sales_q <= '0;
    end else if (state_q == StVend && sales_q != 8'hff) begin
      sales_q <= sales_q + 8'd1;
    end
  end

  assign bus.sales_count = sales_q;
`endif

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed, table-driven bench for vend_ctrl_param at default parameters.
module tb_vend_ctrl_param;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  vend_ctrl_param_if #(.CREDIT_W(4)) bus ();

  vend_ctrl_param #(
    .PRICE      (5),
    .COIN_SMALL (1),
    .COIN_LARGE (2),
    .CREDIT_W   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] coin;
    logic       cancel;
    logic       disp;
    logic       chg;
    logic [3:0] credit;
    logic       busy;
    logic       rej;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] coin, logic cancel, logic disp, logic chg,
                              logic [3:0] credit, logic busy, logic rej);
    vec_t v;
    v.coin   = coin;
    v.cancel = cancel;
    v.disp   = disp;
    v.chg    = chg;
    v.credit = credit;
    v.busy   = busy;
    v.rej    = rej;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic disp, input logic chg,
                            input logic [3:0] credit, input logic busy, input logic rej);
    check({tag, ".dispense"},     int'(bus.dispense),     int'(disp));
    check({tag, ".change_pulse"}, int'(bus.change_pulse), int'(chg));
    check({tag, ".credit"},       int'(bus.credit),       int'(credit));
    check({tag, ".busy"},         int'(bus.busy),         int'(busy));
    check({tag, ".coin_reject"},  int'(bus.coin_reject),  int'(rej));
  endtask

  // Present inputs for one clock, leave the bench at posedge+1.
  task automatic step(input logic [1:0] coin, input logic cancel);
    @(negedge clk);
    bus.coin   = coin;
    bus.cancel = cancel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sales;
    n_cmp      = 0;
    n_err      = 0;
    exp_sales  = 0;
    rst        = 1'b0;
    bus.coin   = 2'b00;
    bus.cancel = 1'b0;

    // Scenario 1: five small coins.
    vecs.push_back(mk(2'b01, 0, 0, 0, 4'd1, 0, 0));
    vecs.push_back(mk(2'b01, 0, 0, 0, 4'd2, 0, 0));
    vecs.push_back(mk(2'b01, 0, 0, 0, 4'd3, 0, 0));
    vecs.push_back(mk(2'b01, 0, 0, 0, 4'd4, 0, 0));
    vecs.push_back(mk(2'b01, 0, 1, 0, 4'd0, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 0, 4'd0, 0, 0));
    // Scenario 2: three large coins, one unit of change.
    vecs.push_back(mk(2'b10, 0, 0, 0, 4'd2, 0, 0));
    vecs.push_back(mk(2'b10, 0, 0, 0, 4'd4, 0, 0));
    vecs.push_back(mk(2'b10, 0, 1, 0, 4'd1, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 1, 4'd1, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 0, 4'd0, 0, 0));
    // Scenario 3: small, large, cancel refunds three units.
    vecs.push_back(mk(2'b01, 0, 0, 0, 4'd1, 0, 0));
    vecs.push_back(mk(2'b10, 0, 0, 0, 4'd3, 0, 0));
    vecs.push_back(mk(2'b00, 1, 0, 1, 4'd3, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 1, 4'd2, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 1, 4'd1, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 0, 4'd0, 0, 0));
    // Scenario 4a: coin during CHANGE is rejected.
    vecs.push_back(mk(2'b01, 0, 0, 0, 4'd1, 0, 0));
    vecs.push_back(mk(2'b10, 0, 0, 0, 4'd3, 0, 0));
    vecs.push_back(mk(2'b00, 1, 0, 1, 4'd3, 1, 0));
    vecs.push_back(mk(2'b01, 0, 0, 1, 4'd2, 1, 1));
    vecs.push_back(mk(2'b00, 0, 0, 1, 4'd1, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 0, 4'd0, 0, 0));
    // Scenario 4b: coin with cancel in COLLECT: cancel wins, coin rejected.
    vecs.push_back(mk(2'b01, 0, 0, 0, 4'd1, 0, 0));
    vecs.push_back(mk(2'b01, 1, 0, 1, 4'd1, 1, 1));
    vecs.push_back(mk(2'b00, 0, 0, 0, 4'd0, 0, 0));
    // Scenario 5: both coin bits count as one large coin.
    vecs.push_back(mk(2'b11, 0, 0, 0, 4'd2, 0, 0));
    vecs.push_back(mk(2'b00, 1, 0, 1, 4'd2, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 1, 4'd1, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 0, 4'd0, 0, 0));
    // Cancel in IDLE is ignored.
    vecs.push_back(mk(2'b00, 1, 0, 0, 4'd0, 0, 0));
    // Coin during VEND is rejected, sale proceeds to change.
    vecs.push_back(mk(2'b10, 0, 0, 0, 4'd2, 0, 0));
    vecs.push_back(mk(2'b10, 0, 0, 0, 4'd4, 0, 0));
    vecs.push_back(mk(2'b10, 0, 1, 0, 4'd1, 1, 0));
    vecs.push_back(mk(2'b01, 0, 0, 1, 4'd1, 1, 1));
    vecs.push_back(mk(2'b00, 0, 0, 0, 4'd0, 0, 0));
    // Exact price, cancel during VEND ignored.
    vecs.push_back(mk(2'b10, 0, 0, 0, 4'd2, 0, 0));
    vecs.push_back(mk(2'b10, 0, 0, 0, 4'd4, 0, 0));
    vecs.push_back(mk(2'b01, 0, 1, 0, 4'd0, 1, 0));
    vecs.push_back(mk(2'b00, 1, 0, 0, 4'd0, 0, 0));

    #1;
    check_outs("reset", 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].coin, vecs[i].cancel);
      check_outs($sformatf("vec%0d", i), vecs[i].disp, vecs[i].chg, vecs[i].credit,
                 vecs[i].busy, vecs[i].rej);
      if (vecs[i].disp) exp_sales++;
    end

`ifdef SALES_CNT_EN
    check("sales_after_table", int'(bus.sales_count), exp_sales);
`endif

    // Scenario 6: asynchronous reset mid-CHANGE with credit 2.
    step(2'b01, 1'b0);
    step(2'b10, 1'b0);
    step(2'b00, 1'b1);
    step(2'b00, 1'b0);
    check_outs("pre_rst", 0, 1, 4'd2, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 4'd0, 0, 0);
`ifdef SALES_CNT_EN
    check("sales_rst", int'(bus.sales_count), 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 1'b0);
      check_outs($sformatf("post_rst%0d", k), 0, 0, 4'd0, 0, 0);
    end

`ifdef SALES_CNT_EN
    for (int s = 0; s < 256; s++) begin
      step(2'b10, 1'b0);
      step(2'b10, 1'b0);
      step(2'b01, 1'b0);
      step(2'b00, 1'b0);
      if (s == 0)   check("sales_first", int'(bus.sales_count), 1);
      if (s == 254) check("sales_255",   int'(bus.sales_count), 255);
    end
    check("sales_saturate", int'(bus.sales_count), 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
Parametrised coin-operated vending controller, the successor to the fixed 2-input vending FSM.
- Accepts small and large coins of configurable value and accumulates credit.
- Dispenses when credit reaches PRICE, then returns any surplus as one change pulse per clock.
- Supports cancel/refund.
- Sits between debounced coin/button inputs and the dispense/change actuator drivers on the lab board.

Parameters:
PRICE, 5, item price in credit units (1 unit = 0.5 yuan)
COIN_SMALL, 1, value of small coin in units
COIN_LARGE, 2, value of large coin in units
CREDIT_W, 4, credit register width; elaboration error unless PRICE-1+COIN_LARGE <= 2**CREDIT_W-1 and PRICE >= 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
coin  input  2  single-cycle coin pulses: bit0 small, bit1 large
cancel  input  1  single-cycle refund request
dispense  output  1  high for exactly one cycle per sale
change_pulse  output  1  high one cycle per returned unit
credit  output  CREDIT_W  current credit
busy  output  1  high in VEND or CHANGE
coin_reject  output  1  registered; high the cycle after a coin pulse is rejected

Behaviour:
- Reset (rst=0, asynchronous, active-low; clock clk):
  - state=IDLE, credit=0.
  - dispense, change_pulse, busy and coin_reject all 0 immediately.
  - Reset mid-VEND/CHANGE abandons the sale; no residual pulses.
- States (3-bit encoding):
  - IDLE: credit==0.
  - COLLECT: credit>0.
  - VEND.
  - CHANGE.
- Outputs:
  - dispense = (state==VEND); change_pulse = (state==CHANGE); busy = VEND|CHANGE.
  - All three are decoded from the state register only.
- Coin value v:
  - coin[1]=1 gives v=COIN_LARGE. Priority: both bits set means only the large coin is counted, with no reject.
  - coin==2'b01 gives v=COIN_SMALL.
- IDLE/COLLECT, coin at edge E, sum = credit+v:
  - sum >= PRICE: state<=VEND, credit<=sum-PRICE.
  - Otherwise: state<=COLLECT, credit<=sum.
- cancel in COLLECT: state<=CHANGE, credit unchanged (refund path, no dispense).
- cancel in IDLE: ignored.
- cancel and coin in the same cycle: cancel wins. The coin is rejected (coin_reject=1 next cycle) and not credited.
- VEND lasts exactly one cycle, then:
  - credit>0: go to CHANGE.
  - credit==0: go to IDLE.
- CHANGE: each edge credit<=credit-1. When credit==1, next state is IDLE. Number of change_pulse cycles therefore equals the surplus.
- Coins during VEND/CHANGE:
  - Rejected: coin_reject=1 for one cycle, credit unaffected.
  - cancel in these states is ignored.
- Latency: coin edge to dispense high = 1 cycle (dispense is high in the cycle following the completing coin's edge).
- Arithmetic is unsigned CREDIT_W bits. Overflow is unreachable by the parameter check; no saturation logic.

Optional Feature:
SALES_CNT_EN
- Defined:
  - Adds output sales_count[7:0], reset to 0.
  - Increments on each cycle in VEND.
  - Saturates at 255; does not wrap.
  - Refunds do not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use default parameters.
1. Reset, then five small coins on separate cycles → credit 1,2,3,4; dispense high one cycle; credit 0; change_pulse never high; returns to IDLE.
2. Three large coins → credit 2,4, then VEND with credit 1; next cycle one change_pulse; credit 0; IDLE; busy high for 2 cycles.
3. Small, large, then cancel → CHANGE with 3 consecutive change_pulse cycles (credit 3,2,1→0); dispense never high.
4. Small coin during CHANGE, and coin together with cancel in COLLECT → coin_reject one cycle each; credit unchanged by the coin.
5. coin=2'b11 from IDLE → credit 2 (large only); no reject.
6. rst low mid-CHANGE (credit 2), asynchronously between edges → change_pulse, busy and credit go to 0 without a clock edge. With SALES_CNT_EN: 256 sales → sales_count holds at 255.
